ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares one single-ported system RAM between three requesters: CPU instruction fetch (I), CPU load/store (D) and the debug/dump port (X).
- X is used by the testbench when override_ctrl is set.
- Sits between the CPU memory interfaces and the RAM model inside the system top.
- Sequences one RAM transaction at a time, returns wait/ready to each requester and detects hung RAM accesses.

Parameters:
- ADDR_W, 32, byte-address width of all ports.
- DATA_W, 32, data word width.
- TIMEOUT, 256, cycles a granted access may wait for ram_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- override_ctrl  in  1  debug port takes exclusive ownership of the RAM.
- iren  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction request not yet complete.
- iload  out  DATA_W  instruction read data.
- dren  in  1  data read request.
- dwen  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dwait  out  1  data request not yet complete.
- dload  out  DATA_W  data read data.
- xren, xwen  in  1 each  debug read/write request.
- xaddr  in  ADDR_W  debug address.
- xstore  in  DATA_W  debug write data.
- xwait  out  1  debug request not yet complete.
- xload  out  DATA_W  debug read data.
- ram_ren, ram_wen  out  1 each  RAM strobes.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid with ram_ready.
- ram_ready  in  1  one-cycle completion pulse from the RAM.
- timeout_err  out  1  sticky; set when the watchdog fires.

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE and the watchdog count to 0.
  - ram_ren, ram_wen and timeout_err go to 0; ram_addr and ram_wdata go to 0.
  - iload, dload and xload go to 0.
  - iwait, dwait and xwait follow their request inputs combinationally, so they read 1 for any request held during reset.
  - Reset mid-transaction drops the RAM strobes immediately; the in-flight result is discarded.
- Requesters hold request, address and data stable until their wait signal is low.
  - waitX = reqX AND NOT (state==GRANT_X AND ram_ready).
  - A request withdrawn during its grant is a protocol violation: the grant still runs to ram_ready and the result is discarded.
- If dren and dwen (or xren and xwen) are both set, the access is treated as a write.
- States: IDLE, GRANT_I, GRANT_D, GRANT_X.
  - IDLE with override_ctrl=1: go to GRANT_X if xren|xwen, else stay in IDLE. I and D are never granted while override_ctrl=1.
  - IDLE with override_ctrl=0: priority is D, then I. X is ignored.
  - GRANT_*: drive ram_* from the granted requester.
  - On ram_ready: pulse the load register update, release wait and return to IDLE. One bubble cycle occurs between back-to-back grants.
- Latency: a request seen in IDLE at edge N is driven to the RAM after edge N+1. With a 1-cycle RAM, wait drops in cycle N+1 (2 cycles total).
- iload, dload and xload are registered from ram_rdata on ram_ready for that port's read. They hold their value until the next read on that port.
- override_ctrl asserted during GRANT_I or GRANT_D: the current access completes, then only X is served.
- Watchdog (TIMEOUT>0):
  - Counter clears on grant entry and increments each GRANT_* cycle.
  - At count==TIMEOUT-1 without ram_ready: abort, release that wait (load data unchanged), set timeout_err and return to IDLE.
  - timeout_err clears only on rst.

Optional Feature:
- Macro: RAM_ARB_ROUND_ROBIN_EN.
- Defined: when D and I are both pending in IDLE, priority alternates. A last_grant flop (reset = I) gives priority to the port not served last.
- Undefined: fixed D-over-I priority; no last_grant flop.
- X behaviour is identical either way.

Decomposition:
- common_types_pkg holds word_t (DATA_W) and the arb_state_t enum {IDLE, GRANT_I, GRANT_D, GRANT_X}.
- Sub-module ram_arb_watchdog: counter, TIMEOUT compare and abort pulse, with a clear input.
- Arbiter FSM and muxes stay in ram_port_arbiter.

Test Plan:
- I-only read at 0x0000_0100 with RAM returning 0xDEADBEEF after 1 cycle -> ram_ren=1 with ram_addr=0x100; iwait low 2 cycles after the request; iload=0xDEADBEEF.
- D write (0x40, 0x12345678) and I read (0x8) raised in the same cycle -> D granted first (ram_wen=1); I granted after one IDLE bubble; with RAM_ARB_ROUND_ROBIN_EN and last_grant=D the I read goes first.
- Continuous D and I requests for 10 transactions, macro undefined -> I starves while D holds; with the macro defined grants alternate D,I,D,I.
- override_ctrl raised mid GRANT_D -> the D access completes; subsequent iren is ignored (iwait stays 1); an xren at 0x0 is served and xload matches RAM contents.
- RAM never returns ram_ready on a D read, TIMEOUT=16 -> dwait drops at grant cycle 16; timeout_err=1 until rst; the next I request is served normally.
- rst asserted during GRANT_I -> ram_ren goes 0 asynchronously; state is IDLE; timeout_err and iload are 0; after release the pending iren is re-granted.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the RAM port arbiter: data word and arbiter state encoding.
package common_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    GRANT_X
  } arb_state_t;

endpackage

// File: rtl/ram_arb_watchdog.sv
// Hung-access watchdog: counts cycles spent in a grant and pulses abort when
// the RAM has not answered by the last allowed cycle. TIMEOUT=0 disables it.
module ram_arb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  input  logic ram_ready,
  output logic abort
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: asynchronous reset in the sensitivity list, and only non-blocking
  // assignments for flop state so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active) begin
      count <= count + CNT_W'(1);
    end
  end

  assign abort = (TIMEOUT > 0) && active && !ram_ready &&
                 (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-ported RAM between instruction fetch (I), load/store (D)
// and the debug port (X). Define RAM_ARB_ROUND_ROBIN_EN to alternate D/I priority.
module ram_port_arbiter
  import common_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              override_ctrl,
  input  logic              iren,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dren,
  input  logic              dwen,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  input  logic              xren,
  input  logic              xwen,
  input  logic [ADDR_W-1:0] xaddr,
  input  logic [DATA_W-1:0] xstore,
  output logic              xwait,
  output logic [DATA_W-1:0] xload,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              timeout_err
);

  arb_state_t state, state_nxt;

  logic ireq, dreq, xreq;
  logic abort, done, in_grant, grant_entry, pick_i, capture;

  assign ireq        = iren;
  assign dreq        = dren | dwen;
  assign xreq        = xren | xwen;
  assign in_grant    = (state != IDLE);
  assign done        = ram_ready | abort;
  assign grant_entry = (state == IDLE) && (state_nxt != IDLE);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Remembers whether D was the last of D/I served; reset value means I.
  logic last_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (grant_entry && state_nxt == GRANT_D) begin
      last_d <= 1'b1;
    end else if (grant_entry && state_nxt == GRANT_I) begin
      last_d <= 1'b0;
    end
  end

  assign pick_i = last_d;
`else
  assign pick_i = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: begin
        if (override_ctrl) begin
          if (xreq) state_nxt = GRANT_X;
        end else if (dreq && !(ireq && pick_i)) begin
          state_nxt = GRANT_D;
        end else if (ireq) begin
          state_nxt = GRANT_I;
        end
      end
      default: begin
        if (done) state_nxt = IDLE;
      end
    endcase
  end

  // RAM side is loaded once on grant entry; requesters hold their inputs stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (grant_entry) begin
      case (state_nxt)
        GRANT_D: begin
          ram_ren   <= !dwen;
          ram_wen   <= dwen;
          ram_addr  <= daddr;
          ram_wdata <= dstore;
        end
        GRANT_X: begin
          ram_ren   <= !xwen;
          ram_wen   <= xwen;
          ram_addr  <= xaddr;
          ram_wdata <= xstore;
        end
        default: begin
          ram_ren  <= 1'b1;
          ram_wen  <= 1'b0;
          ram_addr <= iaddr;
        end
      endcase
    end else if (in_grant && done) begin
      ram_ren <= 1'b0;
      ram_wen <= 1'b0;
    end
  end

  assign iwait = ireq & ~((state == GRANT_I) & done);
  assign dwait = dreq & ~((state == GRANT_D) & done);
  assign xwait = xreq & ~((state == GRANT_X) & done);

  // A read result is kept only if its requester is still asking for it.
  assign capture = ram_ready & ram_ren;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iload <= '0;
      dload <= '0;
      xload <= '0;
    end else begin
      if (capture && state == GRANT_I && iren) iload <= ram_rdata;
      if (capture && state == GRANT_D && dren) dload <= ram_rdata;
      if (capture && state == GRANT_X && xren) xload <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (abort) begin
      timeout_err <= 1'b1;
    end
  end

  ram_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (grant_entry),
    .active   (in_grant),
    .ram_ready(ram_ready),
    .abort    (abort)
  );

endmodule
